// File: rtl/floo_atop_id_alloc_pkg.sv
// Shared types for the atomic ID allocator.
// Each atomic slot tracks which responses are still outstanding before it can be reused.
package floo_atop_id_alloc_pkg;

    typedef struct packed {
        logic b_pend;
        logic r_pend;
    } pend_t;

endpackage

// File: rtl/floo_atop_id_alloc_lzc.sv
// Trailing-zero counter: index of the lowest set bit of in_i, 0 when in_i is all zero.
// empty_o flags the all-zero case so the caller can tell "index 0" from "nothing set".
module floo_atop_id_alloc_lzc #(
    parameter int unsigned Width = 4,
    parameter int unsigned CntW  = 2
) (
    input  logic [Width-1:0] in_i,
    output logic [CntW-1:0]  cnt_o,
    output logic             empty_o
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                cnt_o   = CntW'(i);
                empty_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/floo_atop_id_alloc.sv
// Allocates and recycles AXI IDs for outstanding atomic transactions; an ID returns to the
// free pool only after its B (and R, when the ATOP returns data) response has retired.
module floo_atop_id_alloc
    import floo_atop_id_alloc_pkg::*;
#(
    parameter  int unsigned NumIds   = 4,
    parameter  int unsigned IdWidth  = 2,
    localparam int unsigned CntWidth = $clog2(NumIds + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                alloc_req_i,
    input  logic                alloc_need_r_i,
    input  logic                alloc_commit_i,
    output logic                alloc_avail_o,
    output logic [IdWidth-1:0]  alloc_id_o,
    input  logic                b_rel_i,
    input  logic [IdWidth-1:0]  b_rel_id_i,
    input  logic                r_rel_i,
    input  logic [IdWidth-1:0]  r_rel_id_i,
    output logic [CntWidth-1:0] busy_cnt_o,
    output logic                err_o
);

    typedef logic [IdWidth-1:0] id_t;

    function automatic logic [CntWidth-1:0] popcount(input logic [NumIds-1:0] v);
        logic [CntWidth-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            c = c + CntWidth'(v[i]);
        end
        return c;
    endfunction

    pend_t [NumIds-1:0]  pend_q, pend_d;
    logic  [NumIds-1:0]  free, free_next;
    logic                held_q, held_d;
    id_t                 held_id_q, held_id_d;
    logic [CntWidth-1:0] busy_cnt_q;
    logic                err_q, err_set;
    logic                b_hit, r_hit;
    logic                lz_empty;
    id_t                 lz_id;

    always_comb begin
        for (int unsigned i = 0; i < NumIds; i++) begin
            free[i]      = ~(pend_q[i].b_pend | pend_q[i].r_pend);
            free_next[i] = ~(pend_d[i].b_pend | pend_d[i].r_pend);
        end
    end

    floo_atop_id_alloc_lzc #(
        .Width (NumIds),
        .CntW  (IdWidth)
    ) i_lzc (
        .in_i    (free),
        .cnt_o   (lz_id),
        .empty_o (lz_empty)
    );

    assign alloc_avail_o = ~lz_empty;
    assign alloc_id_o    = held_q ? held_id_q : lz_id;
    assign busy_cnt_o    = busy_cnt_q;
    assign err_o         = err_q;

    // Releases act on the current state; a commit then claims the presented (free) ID.
    always_comb begin
        pend_d  = pend_q;
        err_set = 1'b0;
        b_hit   = 1'b0;
        r_hit   = 1'b0;
        for (int unsigned i = 0; i < NumIds; i++) begin
            if (b_rel_i && (b_rel_id_i == IdWidth'(i))) begin
                b_hit = 1'b1;
                if (pend_q[i].b_pend) pend_d[i].b_pend = 1'b0;
                else                  err_set          = 1'b1;
            end
            if (r_rel_i && (r_rel_id_i == IdWidth'(i))) begin
                r_hit = 1'b1;
                if (pend_q[i].r_pend) pend_d[i].r_pend = 1'b0;
                else                  err_set          = 1'b1;
            end
        end
        if ((b_rel_i && !b_hit) || (r_rel_i && !r_hit)) err_set = 1'b1;

        if (alloc_commit_i) begin
            if (!alloc_avail_o) begin
                err_set = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NumIds; i++) begin
                    if (alloc_id_o == IdWidth'(i)) begin
                        if (pend_q[i].b_pend || pend_q[i].r_pend) err_set = 1'b1;
                        pend_d[i].b_pend = 1'b1;
                        pend_d[i].r_pend = pend_d[i].r_pend | alloc_need_r_i;
                    end
                end
            end
        end

        // The presented ID stays fixed from the first back-pressured cycle until commit.
        held_d    = held_q;
        held_id_d = held_id_q;
        if (alloc_commit_i) begin
            held_d = 1'b0;
        end else if (held_q && !alloc_req_i) begin
            held_d  = 1'b0;
            err_set = 1'b1;
        end else if (!held_q && alloc_req_i && alloc_avail_o) begin
            held_d    = 1'b1;
            held_id_d = lz_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q     <= '0;
            held_q     <= 1'b0;
            held_id_q  <= '0;
            busy_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            held_q     <= held_d;
            held_id_q  <= held_id_d;
            busy_cnt_q <= popcount(~free_next);
            err_q      <= err_q | err_set;
        end
    end

endmodule
